// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives BRAM address, one instruction per cycle into IF/ID; data lags address by one edge.
// Stall holds PC and IF/ID word; redirects cost one bubble. FETCH_PERF_CNT_EN adds stall/bubble counters.
module fetch_stage #(
  parameter int                      PC_WIDTH    = 10,
  parameter int                      INSTR_WIDTH = 18,
  parameter logic [PC_WIDTH-1:0]     INT_VECTOR  = PC_WIDTH'(10'h3FF),
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = INSTR_WIDTH'(18'h00000)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    squash,
  input  logic                    pc_load,
  input  logic [PC_WIDTH-1:0]     pc_load_addr,
  input  logic                    int_take,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]  imem_data,
  output logic [INSTR_WIDTH-1:0]  fetch_instr,
  output logic [PC_WIDTH-1:0]     fetch_pc,
  output logic                    fetch_valid,
  output logic [PC_WIDTH-1:0]     ret_pc,
  output logic [15:0]             stall_cnt,
  output logic [15:0]             bubble_cnt
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [PC_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]      ret_pc_q, ret_pc_d;
  logic [INSTR_WIDTH-1:0]   hold_q, hold_d;
  logic [PC_WIDTH-1:0]      pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    ret_pc_d   = ret_pc_q;
    hold_d     = hold_q;
    if (int_take) begin
      // The word in IF/ID is squashed by the redirect, so it is where execution resumes.
      pc_d     = INT_VECTOR;
      ret_pc_d = fetch_pc_q;
      state_d  = ST_FILL;
    end else if (pc_load) begin
      pc_d    = pc_load_addr;
      state_d = ST_FILL;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          pc_d       = pc_inc;
          fetch_pc_d = pc_q;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            // BRAM moves on to mem[pc] at this edge, so capture the current word now.
            hold_d  = imem_data;
            state_d = ST_HOLD;
          end else begin
            pc_d       = pc_inc;
            fetch_pc_d = pc_q;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            pc_d       = pc_inc;
            fetch_pc_d = pc_q;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      pc_q       <= '0;
      fetch_pc_q <= '0;
      ret_pc_q   <= '0;
      hold_q     <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    fetch_instr = NOP_INSTR;
    fetch_valid = 1'b0;
    if (!squash) begin
      unique case (state_q)
        ST_RUN: begin
          fetch_instr = imem_data;
          fetch_valid = 1'b1;
        end
        ST_HOLD: begin
          fetch_instr = hold_q;
          fetch_valid = 1'b1;
        end
        default: begin
          fetch_instr = NOP_INSTR;
          fetch_valid = 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign fetch_pc  = fetch_pc_q;
  assign ret_pc    = ret_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((state_q != ST_FILL) && stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (!fetch_valid && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = 16'd0;
  assign bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; BRAM model returns mem[a] = a + 0x100 one edge after the address.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        squash;
  logic        pc_load;
  logic [9:0]  pc_load_addr;
  logic        int_take;
  logic [9:0]  imem_addr;
  logic [17:0] imem_data;
  logic [17:0] fetch_instr;
  logic [9:0]  fetch_pc;
  logic        fetch_valid;
  logic [9:0]  ret_pc;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  int n_checks;
  int n_fails;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .squash       (squash),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .int_take     (int_take),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .fetch_instr  (fetch_instr),
    .fetch_pc     (fetch_pc),
    .fetch_valid  (fetch_valid),
    .ret_pc       (ret_pc),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= 18'(imem_addr) + 18'h100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (fetch_instr !== 18'h0) begin n_fails++; $display("FAIL rst_instr got=%h exp=%h", fetch_instr, 18'h0); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid got=%b exp=0", fetch_valid); end
    n_checks++; if (imem_addr !== 10'h0) begin n_fails++; $display("FAIL rst_addr got=%h exp=000", imem_addr); end
    n_checks++; if (fetch_pc !== 10'h0 || ret_pc !== 10'h0) begin n_fails++; $display("FAIL rst_pcs got=%h/%h exp=000/000", fetch_pc, ret_pc); end
    n_checks++; if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin n_fails++; $display("FAIL rst_cnt got=%h/%h exp=0/0", stall_cnt, bubble_cnt); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_run();
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL fill_valid got=%b exp=0", fetch_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (fetch_instr !== 18'h100 + 18'(i) || fetch_pc !== 10'(i) || fetch_valid !== 1'b1) begin
        n_fails++;
        $display("FAIL run%0d got=%h/%h/%b exp=%h/%h/1", i, fetch_instr, fetch_pc, fetch_valid, 18'h100 + 18'(i), 10'(i));
      end
    end
  endtask

  task automatic test_stall();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall = 1'b0;
      #1;
      n_checks++;
      if (fetch_instr !== 18'h105 || fetch_pc !== 10'h005 || fetch_valid !== 1'b1) begin
        n_fails++;
        $display("FAIL stall_hold%0d got=%h/%h/%b exp=105/005/1", i, fetch_instr, fetch_pc, fetch_valid);
      end
      if (i < 3) tick();
    end
    tick();
    n_checks++; if (fetch_instr !== 18'h106 || fetch_pc !== 10'h006) begin n_fails++; $display("FAIL stall_release got=%h/%h exp=106/006", fetch_instr, fetch_pc); end
    tick();
    n_checks++; if (fetch_instr !== 18'h107 || fetch_pc !== 10'h007) begin n_fails++; $display("FAIL stall_next got=%h/%h exp=107/007", fetch_instr, fetch_pc); end
  endtask

  task automatic test_squash();
    squash = 1'b1;
    #1;
    n_checks++; if (fetch_instr !== 18'h0 || fetch_valid !== 1'b0 || fetch_pc !== 10'h007) begin n_fails++; $display("FAIL squash got=%h/%b/%h exp=00000/0/007", fetch_instr, fetch_valid, fetch_pc); end
    tick();
    squash = 1'b0;
    #1;
    n_checks++; if (fetch_instr !== 18'h108 || fetch_pc !== 10'h008 || fetch_valid !== 1'b1) begin n_fails++; $display("FAIL squash_next got=%h/%h/%b exp=108/008/1", fetch_instr, fetch_pc, fetch_valid); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if (bubble_cnt !== 16'd2) begin n_fails++; $display("FAIL bubble_cnt got=%0d exp=2", bubble_cnt); end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fails++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
`else
    n_checks++; if (bubble_cnt !== 16'd0 || stall_cnt !== 16'd0) begin n_fails++; $display("FAIL cnt_tied got=%0d/%0d exp=0/0", bubble_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_pc_load();
    pc_load = 1'b1;
    pc_load_addr = 10'h2A0;
    stall = 1'b1;
    tick();
    pc_load = 1'b0;
    stall = 1'b0;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_instr !== 18'h0 || imem_addr !== 10'h2A0) begin n_fails++; $display("FAIL load_bubble got=%b/%h/%h exp=0/00000/2a0", fetch_valid, fetch_instr, imem_addr); end
    tick();
    n_checks++; if (fetch_pc !== 10'h2A0 || fetch_instr !== 18'h3A0 || fetch_valid !== 1'b1) begin n_fails++; $display("FAIL load_target got=%h/%h/%b exp=2a0/003a0/1", fetch_pc, fetch_instr, fetch_valid); end
  endtask

  task automatic test_int_take();
    pc_load = 1'b1;
    pc_load_addr = 10'h010;
    tick();
    pc_load = 1'b0;
    tick();
    tick();
    tick();
    stall = 1'b1;
    tick();
    n_checks++; if (fetch_pc !== 10'h012 || fetch_instr !== 18'h112 || fetch_valid !== 1'b1) begin n_fails++; $display("FAIL int_pre got=%h/%h/%b exp=012/00112/1", fetch_pc, fetch_instr, fetch_valid); end
    int_take = 1'b1;
    tick();
    int_take = 1'b0;
    stall = 1'b0;
    #1;
    n_checks++; if (ret_pc !== 10'h012) begin n_fails++; $display("FAIL int_ret_pc got=%h exp=012", ret_pc); end
    n_checks++; if (fetch_valid !== 1'b0 || imem_addr !== 10'h3FF) begin n_fails++; $display("FAIL int_bubble got=%b/%h exp=0/3ff", fetch_valid, imem_addr); end
    tick();
    n_checks++; if (fetch_pc !== 10'h3FF || fetch_instr !== 18'h4FF || fetch_valid !== 1'b1 || imem_addr !== 10'h000) begin n_fails++; $display("FAIL int_vector got=%h/%h/%b/%h exp=3ff/004ff/1/000", fetch_pc, fetch_instr, fetch_valid, imem_addr); end
    tick();
    n_checks++; if (fetch_pc !== 10'h000 || fetch_instr !== 18'h100) begin n_fails++; $display("FAIL int_wrap got=%h/%h exp=000/00100", fetch_pc, fetch_instr); end
  endtask

  task automatic test_squash_hold();
    stall = 1'b1;
    tick();
    squash = 1'b1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_instr !== 18'h0) begin n_fails++; $display("FAIL sq_hold got=%b/%h exp=0/00000", fetch_valid, fetch_instr); end
    squash = 1'b0;
    #1;
    n_checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 18'h100 || fetch_pc !== 10'h000) begin n_fails++; $display("FAIL sq_hold_after got=%b/%h/%h exp=1/00100/000", fetch_valid, fetch_instr, fetch_pc); end
  endtask

  task automatic test_async_reset();
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_instr !== 18'h0 || imem_addr !== 10'h0) begin n_fails++; $display("FAIL arst_out got=%b/%h/%h exp=0/00000/000", fetch_valid, fetch_instr, imem_addr); end
    n_checks++; if (fetch_pc !== 10'h0 || ret_pc !== 10'h0) begin n_fails++; $display("FAIL arst_pcs got=%h/%h exp=000/000", fetch_pc, ret_pc); end
    stall = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL arst_fill got=%b exp=0", fetch_valid); end
    tick();
    n_checks++; if (fetch_instr !== 18'h100 || fetch_pc !== 10'h000 || fetch_valid !== 1'b1) begin n_fails++; $display("FAIL arst_first got=%h/%h/%b exp=00100/000/1", fetch_instr, fetch_pc, fetch_valid); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    reset        = 1'b1;
    stall        = 1'b0;
    squash       = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = 10'h0;
    int_take     = 1'b0;
    test_reset();
    test_run();
    test_stall();
    test_squash();
    test_pc_load();
    test_int_take();
    test_squash_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RAT core. Sits directly upstream of pipeline_control and the decode stage.
- Owns the program counter and drives the synchronous instruction-memory (BRAM) address. Presents one instruction per cycle to decode through the IF/ID register.
- Obeys the stall, squash, branch-redirect and interrupt-redirect commands issued by pipeline_control.

Parameters:
- PC_WIDTH, 10, program counter and instruction-memory address width.
- INSTR_WIDTH, 18, instruction word width.
- INT_VECTOR, 10'h3FF, interrupt handler address.
- NOP_INSTR, 18'h00000, encoding injected on bubbles and squashes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and the IF/ID contents (pipeline_control pc_stall).
- squash  in  1  force NOP with fetch_valid=0 this cycle (pipeline_control dec_nop).
- pc_load  in  1  branch/return redirect request.
- pc_load_addr  in  PC_WIDTH  redirect target.
- int_take  in  1  interrupt redirect request.
- imem_addr  out  PC_WIDTH  BRAM read address; data is valid one edge later.
- imem_data  in  INSTR_WIDTH  BRAM read data.
- fetch_instr  out  INSTR_WIDTH  instruction presented to decode.
- fetch_pc  out  PC_WIDTH  address of fetch_instr.
- fetch_valid  out  1  fetch_instr is a real, non-squashed instruction.
- ret_pc  out  PC_WIDTH  return address captured on int_take.
- stall_cnt  out  16  stall-cycle counter (optional feature).
- bubble_cnt  out  16  bubble-cycle counter (optional feature).

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: pc=0, state=FILL, fetch_pc=0, ret_pc=0, hold_reg=NOP_INSTR, both counters=0. Outputs during reset: fetch_instr=NOP_INSTR, fetch_valid=0, imem_addr=0.
- imem_addr is always the pc register (no combinational path from inputs).
- FILL state (BRAM data stale):
  - fetch_instr=NOP_INSTR, fetch_valid=0.
  - At the edge: pc<=pc+1, fetch_pc<=pc, state<=RUN.
  - stall is ignored in FILL.
- RUN state:
  - fetch_instr=imem_data, fetch_valid=1.
  - stall=0 at the edge: pc<=pc+1, fetch_pc<=pc.
  - stall=1 at the edge: hold_reg<=imem_data; pc and fetch_pc unchanged; state<=HOLD.
- HOLD state:
  - fetch_instr=hold_reg, fetch_valid=1.
  - stall=1: remain in HOLD.
  - stall=0 at the edge: pc<=pc+1, fetch_pc<=pc, state<=RUN. The next cycle therefore presents mem[old pc] with no instruction lost or duplicated.
- squash:
  - Purely combinational: fetch_instr=NOP_INSTR, fetch_valid=0.
  - No effect on state, pc or hold_reg.
  - A squash during HOLD masks the held word only for that cycle.
- Redirect priority: reset > int_take > pc_load > stall > sequential advance.
- int_take (any state):
  - At the edge: pc<=INT_VECTOR, ret_pc<=fetch_pc, state<=FILL.
  - ret_pc is the address of the instruction in IF/ID at that edge, which is the one being squashed and later resumed.
- pc_load (any state, int_take=0):
  - At the edge: pc<=pc_load_addr, state<=FILL.
  - Overrides a simultaneous stall.
  - Costs exactly one fetch bubble.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so 0x3FF+1 = 0x000 with no flag.
- Reset mid-operation: asynchronously returns every register to its reset value. The first valid instruction appears 1 cycle after reset deasserts (mem[0], fetch_pc=0).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge where state is RUN or HOLD and stall=1.
  - bubble_cnt increments on each edge where fetch_valid=0.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: no counter registers; stall_cnt and bubble_cnt are tied to 0.

Test Plan:
- Reset, then run with no stall (mem[i]=i+0x100) -> cycle 0 valid=0; cycles 1..4 show fetch_instr=0x100..0x103, fetch_pc=0..3.
- stall high 3 cycles while fetch_pc=5 -> fetch_instr=mem[5] for 4 cycles; after release mem[6] with fetch_pc=6, no duplicate or skip.
- pc_load=1, addr=0x2A0 together with stall=1 -> 1 cycle valid=0; then fetch_pc=0x2A0 and mem[0x2A0]; stall ignored on the load edge.
- int_take while fetch_pc=0x012 in HOLD -> ret_pc=0x012; 1 bubble; then fetch_pc=0x3FF; then 0x000 (wrap).
- squash for 1 cycle in RUN at fetch_pc=7 -> that cycle NOP/valid=0; next cycle fetch_pc=8. With FETCH_PERF_CNT_EN defined, bubble_cnt reaches 2 (including the reset fill).
- Assert reset asynchronously mid-HOLD -> outputs go to reset values immediately; first valid instruction is mem[0] one cycle after release.
